// File: rtl/proc_pkg.sv
// Shared processor definitions.
// Holds the default scalar/line widths and the memory-stage FSM state type.
package proc_pkg;

   localparam int unsigned WORD_W = 36;
   localparam int unsigned LINE_W = 128;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } mem_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage.
// ALU results pass straight to writeback. Legal loads and stores are issued
// to the cache over a valid/ready request channel. Loads then wait for a
// response and write it back. Illegal ops raise a one-cycle err pulse.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_valid, mem_read,
//   mem_write, vec_op, addr,
//   store_sdata, store_vdata,
//   wb_reg_in                    op from the execute/memory register
//   stall                        upstream hold (stage busy)
//   req_*                        cache request channel
//   resp_valid, resp_data        cache load response
//   wb_*, register_wb, vector_wb writeback
//   err                          illegal-op pulse
module mem_stage
   import proc_pkg::*;
#(
   parameter int unsigned WORD_W = proc_pkg::WORD_W,
   parameter int unsigned LINE_W = proc_pkg::LINE_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              vec_op,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] store_sdata,
   input  logic [LINE_W-1:0] store_vdata,
   input  logic [4:0]        wb_reg_in,
   output logic              stall,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_write,
   output logic              req_vec,
   output logic [WORD_W-1:0] req_addr,
   output logic [LINE_W-1:0] req_wdata,
   input  logic              resp_valid,
   input  logic [LINE_W-1:0] resp_data,
   output logic              wb_valid,
   output logic              wb_vec,
   output logic [4:0]        wb_reg,
   output logic [WORD_W-1:0] register_wb,
   output logic [LINE_W-1:0] vector_wb,
   output logic              err
);

   mem_state_t state_q, state_d;

   logic              req_valid_q, req_valid_d;
   logic              req_write_q, req_write_d;
   logic              req_vec_q, req_vec_d;
   logic [WORD_W-1:0] req_addr_q, req_addr_d;
   logic [LINE_W-1:0] req_wdata_q, req_wdata_d;
   logic [4:0]        tag_q, tag_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_vec_q, wb_vec_d;
   logic [4:0]        wb_reg_q, wb_reg_d;
   logic [WORD_W-1:0] register_wb_q, register_wb_d;
   logic [LINE_W-1:0] vector_wb_q, vector_wb_d;
   logic              err_q, err_d;

   logic accept, is_mem, illegal;

   assign accept  = (state_q == StIdle) && ex_valid;
   assign is_mem  = mem_read | mem_write;
   // Vector lines must be 4-aligned; read+write together has no meaning.
   assign illegal = (mem_read && mem_write) || (is_mem && vec_op && (addr[1:0] != 2'b00));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept && is_mem && !illegal) state_d = StReq;
         StReq:   if (req_ready) state_d = req_write_q ? StIdle : StWait;
         StWait:  if (resp_valid) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output / datapath next values; every visible output is a register.
   always_comb begin
      req_valid_d   = req_valid_q;
      req_write_d   = req_write_q;
      req_vec_d     = req_vec_q;
      req_addr_d    = req_addr_q;
      req_wdata_d   = req_wdata_q;
      tag_d         = tag_q;
      wb_valid_d    = 1'b0;
      wb_vec_d      = wb_vec_q;
      wb_reg_d      = wb_reg_q;
      register_wb_d = register_wb_q;
      vector_wb_d   = vector_wb_q;
      err_d         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (illegal) begin
                  err_d = 1'b1;
               end else if (is_mem) begin
                  req_valid_d = 1'b1;
                  req_write_d = mem_write;
                  req_vec_d   = vec_op;
                  req_addr_d  = addr;
                  req_wdata_d = vec_op ? store_vdata
                                       : {{(LINE_W-WORD_W){1'b0}}, store_sdata};
                  tag_d       = wb_reg_in;
               end else begin
                  wb_valid_d    = 1'b1;
                  wb_vec_d      = 1'b0;
                  wb_reg_d      = wb_reg_in;
                  register_wb_d = addr;
               end
            end
         end
         StReq: begin
            if (req_ready) req_valid_d = 1'b0;
         end
         StWait: begin
            if (resp_valid) begin
               wb_valid_d = 1'b1;
               wb_vec_d   = req_vec_q;
               wb_reg_d   = tag_q;
               if (req_vec_q) vector_wb_d   = resp_data;
               else           register_wb_d = resp_data[WORD_W-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_valid_q   <= 1'b0;
         req_write_q   <= 1'b0;
         req_vec_q     <= 1'b0;
         req_addr_q    <= '0;
         req_wdata_q   <= '0;
         tag_q         <= '0;
         wb_valid_q    <= 1'b0;
         wb_vec_q      <= 1'b0;
         wb_reg_q      <= '0;
         register_wb_q <= '0;
         vector_wb_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         req_valid_q   <= req_valid_d;
         req_write_q   <= req_write_d;
         req_vec_q     <= req_vec_d;
         req_addr_q    <= req_addr_d;
         req_wdata_q   <= req_wdata_d;
         tag_q         <= tag_d;
         wb_valid_q    <= wb_valid_d;
         wb_vec_q      <= wb_vec_d;
         wb_reg_q      <= wb_reg_d;
         register_wb_q <= register_wb_d;
         vector_wb_q   <= vector_wb_d;
         err_q         <= err_d;
      end
   end

   assign stall       = (state_q != StIdle);
   assign req_valid   = req_valid_q;
   assign req_write   = req_write_q;
   assign req_vec     = req_vec_q;
   assign req_addr    = req_addr_q;
   assign req_wdata   = req_wdata_q;
   assign wb_valid    = wb_valid_q;
   assign wb_vec      = wb_vec_q;
   assign wb_reg      = wb_reg_q;
   assign register_wb = register_wb_q;
   assign vector_wb   = vector_wb_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         ex_valid, mem_read, mem_write, vec_op;
   logic [35:0]  addr, store_sdata;
   logic [127:0] store_vdata;
   logic [4:0]   wb_reg_in;
   logic         stall, req_valid, req_ready, req_write, req_vec;
   logic [35:0]  req_addr;
   logic [127:0] req_wdata;
   logic         resp_valid;
   logic [127:0] resp_data;
   logic         wb_valid, wb_vec;
   logic [4:0]   wb_reg;
   logic [35:0]  register_wb;
   logic [127:0] vector_wb;
   logic         err;

   mem_stage dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
      .mem_write(mem_write), .vec_op(vec_op), .addr(addr),
      .store_sdata(store_sdata), .store_vdata(store_vdata), .wb_reg_in(wb_reg_in),
      .stall(stall), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_vec(req_vec), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
      .wb_valid(wb_valid), .wb_vec(wb_vec), .wb_reg(wb_reg),
      .register_wb(register_wb), .vector_wb(vector_wb), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]   tag;
      logic         vec;
      logic [35:0]  rwb;
      logic [127:0] vwb;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] tag, input logic vec, input logic [35:0] rwb,
                       input logic [127:0] vwb);
      wb_exp_t e;
      e.tag = tag; e.vec = vec; e.rwb = rwb; e.vwb = vwb;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic rd, input logic wr, input logic vec, input logic [35:0] a,
                        input logic [4:0] tag);
      ex_valid = 1'b1; mem_read = rd; mem_write = wr; vec_op = vec; addr = a; wb_reg_in = tag;
   endtask

   // Scoreboard monitor: every writeback pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (wb_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wb", 128'(wb_valid), 128'(0));
         end else begin
            wb_exp_t e;
            e = exp_q.pop_front();
            chk("wb_reg", 128'(wb_reg), 128'(e.tag));
            chk("wb_vec", 128'(wb_vec), 128'(e.vec));
            if (e.vec) chk("vector_wb", vector_wb, e.vwb);
            else       chk("register_wb", 128'(register_wb), 128'(e.rwb));
         end
      end
   end

   initial begin
      rst = 1'b1; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; vec_op = 1'b0;
      addr = '0; store_sdata = '0; store_vdata = '0; wb_reg_in = '0;
      req_ready = 1'b1; resp_valid = 1'b0; resp_data = '0;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", 128'(stall), 128'(0));
      chk("rst_req_valid", 128'(req_valid), 128'(0));
      chk("rst_wb_valid", 128'(wb_valid), 128'(0));
      chk("rst_err", 128'(err), 128'(0));
      chk("rst_register_wb", 128'(register_wb), 128'(0));
      chk("rst_req_addr", 128'(req_addr), 128'(0));

      // ALU passthrough
      tick();
      drive(1'b0, 1'b0, 1'b0, 36'h0_0000_00AB, 5'd5);
      push(5'd5, 1'b0, 36'hAB, '0);
      tick();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("alu_wb_valid", 128'(wb_valid), 128'(1));
      chk("alu_stall", 128'(stall), 128'(0));

      // Scalar load, zero-wait cache
      tick();
      drive(1'b1, 1'b0, 1'b0, 36'h100, 5'd7);
      push(5'd7, 1'b0, 36'h9_1234_5678, '0);
      tick();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("ld_stall_c1", 128'(stall), 128'(1));
      chk("ld_req_valid", 128'(req_valid), 128'(1));
      chk("ld_req_addr", 128'(req_addr), 128'(36'h100));
      chk("ld_req_write", 128'(req_write), 128'(0));
      chk("ld_wb_c1", 128'(wb_valid), 128'(0));
      tick();
      resp_valid = 1'b1;
      resp_data = {92'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A, 36'h9_1234_5678};
      @(negedge clk);
      chk("ld_stall_c2", 128'(stall), 128'(1));
      chk("ld_req_drop", 128'(req_valid), 128'(0));
      chk("ld_wb_c2", 128'(wb_valid), 128'(0));
      tick();
      resp_valid = 1'b0;
      @(negedge clk);
      chk("ld_stall_c3", 128'(stall), 128'(1));
      chk("ld_wb_c3", 128'(wb_valid), 128'(1));
      tick();
      @(negedge clk);
      chk("ld_stall_end", 128'(stall), 128'(0));
      chk("ld_wb_once", 128'(wb_valid), 128'(0));

      // Vector store with back-pressure
      tick();
      req_ready = 1'b0;
      store_vdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      drive(1'b0, 1'b1, 1'b1, 36'h40, 5'd9);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("vst_req_valid", 128'(req_valid), 128'(1));
         chk("vst_req_addr", 128'(req_addr), 128'(36'h40));
         chk("vst_req_wdata", req_wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
         chk("vst_req_wrvec", 128'({req_write, req_vec}), 128'(2'b11));
         if (i == 4) req_ready = 1'b1;
         tick();
      end
      @(negedge clk);
      chk("vst_idle", 128'(stall), 128'(0));
      chk("vst_req_done", 128'(req_valid), 128'(0));

      // Scalar store zero-extends data
      tick();
      store_sdata = 36'hF_0000_0001;
      drive(1'b0, 1'b1, 1'b0, 36'h80, 5'd2);
      tick();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("sst_wdata", req_wdata, 128'h0000_0000_0000_0000_0000_000F_0000_0001);
      tick();

      // Misaligned vector load is illegal
      drive(1'b1, 1'b0, 1'b1, 36'h41, 5'd4);
      tick();
      ex_valid = 1'b0;
      @(negedge clk);
      chk("ill_err", 128'(err), 128'(1));
      chk("ill_req_valid", 128'(req_valid), 128'(0));
      chk("ill_stall", 128'(stall), 128'(0));
      tick();
      @(negedge clk);
      chk("ill_err_pulse", 128'(err), 128'(0));

      // Aligned vector load
      tick();
      drive(1'b1, 1'b0, 1'b1, 36'h80, 5'd12);
      push(5'd12, 1'b1, '0, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
      tick();
      ex_valid = 1'b0;
      tick();
      resp_valid = 1'b1;
      resp_data = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      tick();
      resp_valid = 1'b0;
      tick();

      // Reset during WAIT abandons the load; a stale response is ignored
      drive(1'b1, 1'b0, 1'b0, 36'h200, 5'd3);
      tick();
      ex_valid = 1'b0;
      tick();
      @(negedge clk);
      chk("rw_stall_wait", 128'(stall), 128'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      resp_valid = 1'b1;
      resp_data = 128'h77;
      tick();
      resp_valid = 1'b0;
      @(negedge clk);
      chk("rw_stall", 128'(stall), 128'(0));
      chk("rw_wb_valid", 128'(wb_valid), 128'(0));
      chk("rw_register_wb", 128'(register_wb), 128'(0));
      tick();
      @(negedge clk);
      chk("rw_wb_late", 128'(wb_valid), 128'(0));

      // Four back-to-back ALU ops
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0, 36'h1000 + 36'(k), 5'(10 + k));
         push(5'(10 + k), 1'b0, 36'h1000 + 36'(k), '0);
         tick();
         @(negedge clk);
         chk("b2b_wb_valid", 128'(wb_valid), 128'(1));
         chk("b2b_stall", 128'(stall), 128'(0));
      end
      ex_valid = 1'b0;
      tick();
      tick();
      chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
